// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: mux/op codes and FSM states.
package shift_sequencer_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command handshake bundle between the requester and the shift sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/shift_sequencer_mux_4to1.sv
// One-bit 4:1 mux selecting the next state of a single register bit.
module mux_4to1 (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_d,
  input  logic [1:0] i_m,
  output logic       o_y
);

  // Select hold / shift-right source / shift-left source / load bit.
  always_comb begin
    o_y = i_a;
    case (i_m)
      2'b00:   o_y = i_a;
      2'b01:   o_y = i_b;
      2'b10:   o_y = i_c;
      default: o_y = i_d;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven universal shift register: sequencer FSM, shift counter and
// q flops, with a per-bit 4:1 next-state mux steered by the registered mode.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_sequencer_if.slave    cmd,
  input  logic                sr_in,
  input  logic                sl_in,
  output logic [1:0]          mode,
  output logic [WIDTH-1:0]    q,
  output logic                busy,
  output logic                done
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       r_mode;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_eff_cnt;
  logic [WIDTH-1:0] w_sr_vec;
  logic [WIDTH-1:0] w_sl_vec;
  logic [WIDTH-1:0] w_q_next;
  logic             w_accept;

  // Shift sources: right shift pulls from the bit above, left from the bit below.
  assign w_sr_vec = {sr_in, r_q[WIDTH-1:1]};
  assign w_sl_vec = {r_q[WIDTH-2:0], sl_in};

  assign w_accept = cmd.cmd_valid && r_ready;

  // Effective cycle count of an incoming command: load is one step, nop none.
  always_comb begin
    w_eff_cnt = '0;
    case (cmd.cmd_op)
      MODE_SR, MODE_SL: w_eff_cnt = cmd.cmd_count;
      MODE_LOAD:        w_eff_cnt = CNT_W'(1);
      default:          w_eff_cnt = '0;
    endcase
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    mux_4to1 u_mux (
      .i_a (r_q[i]),
      .i_b (w_sr_vec[i]),
      .i_c (w_sl_vec[i]),
      .i_d (r_data[i]),
      .i_m (r_mode),
      .o_y (w_q_next[i])
    );
  end

  // Sequencer FSM with registered mode/ready/busy/done and the q register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= MODE_HOLD;
      r_data  <= '0;
      r_q     <= '0;
      r_mode  <= MODE_HOLD;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd.cmd_op;
            r_data  <= cmd.cmd_data;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_eff_cnt == '0) begin
              r_state <= S_DONE;
              r_mode  <= MODE_HOLD;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= w_eff_cnt;
              r_mode  <= cmd.cmd_op;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_mode  <= MODE_HOLD;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_mode  <= MODE_HOLD;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Ready and mode read as zero while reset is asserted.
  assign cmd.cmd_ready = rst_n & r_ready;
  assign mode          = rst_n ? r_mode : MODE_HOLD;
  assign q             = r_q;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand sequences plus a command table.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sr_in;
  logic       sl_in;
  logic [1:0] mode;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  shift_sequencer_if #(.WIDTH(8), .CNT_W(4)) cif ();

  shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cif),
    .sr_in (sr_in),
    .sl_in (sl_in),
    .mode  (mode),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] cnt;
    logic [7:0] data;
    logic       sr;
    logic       sl;
    logic [7:0] exp_q;
    int         exp_lat;
    int         exp_mc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present a command at a falling edge and hold it until it is accepted.
  task automatic accept(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data,
                        input logic sr, input logic sl);
    int waited = 0;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_count = cnt;
    cif.cmd_data  = data;
    sr_in         = sr;
    sl_in         = sl;
    while (!cif.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(waited < 50), 32'd1);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int mc;
    logic mode_ok;

    vecs[0]  = '{2'b11, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 2,  1};
    vecs[1]  = '{2'b10, 4'd3,  8'h00, 1'b0, 1'b1, 8'h2F, 4,  3};
    vecs[2]  = '{2'b01, 4'd2,  8'hFF, 1'b0, 1'b0, 8'h0B, 3,  2};
    vecs[3]  = '{2'b01, 4'd0,  8'h00, 1'b1, 1'b1, 8'h0B, 1,  0};
    vecs[4]  = '{2'b00, 4'd5,  8'h77, 1'b1, 1'b1, 8'h0B, 1,  0};
    vecs[5]  = '{2'b01, 4'd15, 8'h00, 1'b1, 1'b0, 8'hFF, 16, 15};
    vecs[6]  = '{2'b10, 4'd9,  8'h00, 1'b1, 1'b0, 8'h00, 10, 9};
    vecs[7]  = '{2'b11, 4'd7,  8'h3C, 1'b0, 1'b0, 8'h3C, 2,  1};
    vecs[8]  = '{2'b10, 4'd1,  8'h00, 1'b1, 1'b0, 8'h78, 2,  1};
    vecs[9]  = '{2'b01, 4'd4,  8'h00, 1'b1, 1'b0, 8'hF7, 5,  4};
    vecs[10] = '{2'b11, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 2,  1};
    vecs[11] = '{2'b10, 4'd8,  8'h00, 1'b0, 1'b1, 8'hFF, 9,  8};

    rst_n         = 1'b0;
    sr_in         = 1'b0;
    sl_in         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_count = 4'd0;
    cif.cmd_data  = 8'h00;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(q), 32'h00);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cif.cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(cif.cmd_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // Load A5: one load cycle, done two cycles after accept.
    accept(2'b11, 4'd0, 8'hA5, 1'b0, 1'b0);
    check("ld_mode", 32'(mode), 32'd3);
    check("ld_q_pre", 32'(q), 32'h00);
    check("ld_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("ld_q", 32'(q), 32'hA5);
    check("ld_mode_after", 32'(mode), 32'd0);
    check("ld_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("ld_done_end", 32'(done), 32'd0);
    check("ld_ready", 32'(cif.cmd_ready), 32'd1);

    // Shift left by 3 with ones fill.
    accept(2'b10, 4'd3, 8'h00, 1'b0, 1'b1);
    check("sl_mode1", 32'(mode), 32'd2);
    @(posedge clk); #1;
    check("sl_q1", 32'(q), 32'h4B);
    check("sl_mode2", 32'(mode), 32'd2);
    @(posedge clk); #1;
    check("sl_q2", 32'(q), 32'h97);
    check("sl_mode3", 32'(mode), 32'd2);
    @(posedge clk); #1;
    check("sl_q3", 32'(q), 32'h2F);
    check("sl_done", 32'(done), 32'd1);
    check("sl_mode_done", 32'(mode), 32'd0);

    // Shift right by 2, with a nop held on valid the whole time it runs.
    accept(2'b01, 4'd2, 8'h00, 1'b0, 1'b0);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b00;
    check("sr_ready_busy", 32'(cif.cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("sr_q1", 32'(q), 32'h17);
    check("sr_ready_run", 32'(cif.cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("sr_q2", 32'(q), 32'h0B);
    check("sr_done", 32'(done), 32'd1);
    check("sr_ready_done", 32'(cif.cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("hold_idle_ready", 32'(cif.cmd_ready), 32'd1);
    check("hold_idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    check("hold_nop_done", 32'(done), 32'd1);
    check("hold_nop_q", 32'(q), 32'h0B);
    check("hold_nop_mode", 32'(mode), 32'd0);
    @(posedge clk); #1;
    check("hold_nop_done_end", 32'(done), 32'd0);

    // Shift with count 0 finishes immediately without touching q.
    accept(2'b01, 4'd0, 8'h00, 1'b1, 1'b1);
    check("c0_done", 32'(done), 32'd1);
    check("c0_mode", 32'(mode), 32'd0);
    check("c0_q", 32'(q), 32'h0B);

    // Long shift right aborted by reset on its fourth run cycle.
    accept(2'b01, 4'd10, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ab_q_before", 32'(q), 32'hE1);
    check("ab_mode_before", 32'(mode), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_mode_forced", 32'(mode), 32'd0);
    check("ab_ready_forced", 32'(cif.cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("ab_q", 32'(q), 32'h00);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) mc++;
    end
    check("ab_no_done", 32'(mc), 32'd0);
    check("ab_idle_ready", 32'(cif.cmd_ready), 32'd1);

    // Command table: final q, accept-to-done latency and mode-active cycles.
    for (int v = 0; v < 12; v++) begin
      accept(vecs[v].op, vecs[v].cnt, vecs[v].data, vecs[v].sr, vecs[v].sl);
      lat     = 1;
      mc      = 0;
      mode_ok = 1'b1;
      while (!done && lat < 40) begin
        if (mode != 2'b00) begin
          mc++;
          if (mode != vecs[v].op) mode_ok = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("tbl%0d_q", v), 32'(q), 32'(vecs[v].exp_q));
      check($sformatf("tbl%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("tbl%0d_modecyc", v), 32'(mc), 32'(vecs[v].exp_mc));
      check($sformatf("tbl%0d_modeval", v), 32'(mode_ok), 32'd1);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", v), 32'(done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
